// File: rtl/mac_vlg_pkg.sv
// Shared definitions for the MAC store-and-forward frame FIFO.
//   rd_state_t   : read-side FSM states (idle, frame readout, inter-frame gap)
//   DROP_CNT_W   : width of the discarded-frame counter
//   DROP_CNT_MAX : saturation value of that counter
package mac_vlg_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_READ = 2'd1,
        RD_GAP  = 2'd2
    } rd_state_t;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/mac_vlg_frame_fifo_ram.sv
// Simple dual-port RAM for the frame FIFO data buffer: one write port and one
// read port whose data is registered (one cycle latency). No reset, so it maps
// onto block RAM.
//   clk   : clock for both ports
//   we    : write enable, waddr/wdata : write address and data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, valid the cycle after re
module mac_vlg_frame_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mac_vlg_frame_fifo.sv
// Store-and-forward frame FIFO. Frames are written as contiguous valid_in runs
// and only become readable once complete and error-free; bad or oversized
// frames are rolled back and counted. Committed frame lengths are held in a
// small length queue that drives the read FSM.
//   clk, rst              : clock, asynchronous active-high reset
//   data_in/valid_in      : write stream, one high run of valid_in = one frame
//   error_in              : marks the current frame bad when seen with valid_in
//   data_out/valid_out    : read stream, valid_out gap-free for a whole frame
//   sof_out/eof_out       : first / last word markers of an output frame
//   drop_cnt              : saturating count of discarded frames
//   overflow              : one-cycle pulse when a frame is dropped for space
//
// Stream semantics: there is no back-pressure in either direction. A word is
// transferred on every clock edge where valid_in (or valid_out) is high; the
// producer cannot be stalled and the consumer must accept every valid word.
module mac_vlg_frame_fifo
    import mac_vlg_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_DEPTH  = 3,
    parameter int IFG        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  valid_in,
    input  logic                  error_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic                  sof_out,
    output logic                  eof_out,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  overflow
);

    localparam int PTR_W      = FIFO_DEPTH + 1;
    localparam int LQ_PTR_W   = LEN_DEPTH + 1;
    localparam int LQ_ENTRIES = 2**LEN_DEPTH;
    localparam logic [PTR_W-1:0] FIFO_WORDS = {1'b1, {FIFO_DEPTH{1'b0}}};
    localparam logic [PTR_W-1:0] LEN_ONE    = PTR_W'(1);
    localparam logic [3:0]       IFG_M1     = 4'(IFG - 1);

    // ---------------- write side ----------------
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] commit_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] frame_len;
    logic [PTR_W-1:0] used;
    logic             prev_valid;
    logic             bad;
    logic             bad_ovf;
    logic             no_space;
    logic             wr_en;
    logic             frame_end;
    logic             frame_drop;
    logic             drop_ovf;

    // ---------------- length queue ----------------
    logic [PTR_W-1:0]    lq_mem [LQ_ENTRIES];
    logic [LQ_PTR_W-1:0] lq_wr_ptr;
    logic [LQ_PTR_W-1:0] lq_rd_ptr;
    logic [PTR_W-1:0]    lq_head;
    logic                lq_full;
    logic                lq_empty;
    logic                lq_push;
    logic                lq_pop;

    // ---------------- read side ----------------
    rd_state_t         rd_state;
    rd_state_t         rd_state_d;
    logic [PTR_W-1:0]  rem_q;
    logic [PTR_W-1:0]  rem_d;
    logic [3:0]        gap_q;
    logic [3:0]        gap_d;
    logic              rd_en;
    logic              rd_sof;
    logic              rd_eof;
    logic              rd_vld_q;
    logic              rd_sof_q;
    logic              rd_eof_q;
    logic [DATA_W-1:0] ram_rdata;

    // Occupancy counts words still owned by the reader; extra MSB on the
    // pointers distinguishes a full buffer from an empty one.
    assign used      = wr_ptr - rd_ptr;
    assign no_space  = (used == FIFO_WORDS);
    assign wr_en     = valid_in && !no_space;
    assign frame_end = prev_valid && !valid_in;

    assign lq_empty = (lq_wr_ptr == lq_rd_ptr);
    assign lq_full  = (lq_wr_ptr[LEN_DEPTH] != lq_rd_ptr[LEN_DEPTH]) &&
                      (lq_wr_ptr[LEN_DEPTH-1:0] == lq_rd_ptr[LEN_DEPTH-1:0]);
    assign lq_head  = lq_mem[lq_rd_ptr[LEN_DEPTH-1:0]];

    // A good frame with nowhere to record its length is dropped like an
    // overflowed one.
    assign lq_push    = frame_end && !bad && !lq_full;
    assign frame_drop = frame_end && (bad || lq_full);
    assign drop_ovf   = frame_end && (bad_ovf || (!bad && lq_full));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            frame_len  <= '0;
            prev_valid <= 1'b0;
            bad        <= 1'b0;
            bad_ovf    <= 1'b0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            lq_wr_ptr  <= '0;
            for (int i = 0; i < LQ_ENTRIES; i++) begin
                lq_mem[i] <= '0;
            end
        end else begin
            prev_valid <= valid_in;
            overflow   <= drop_ovf;
            if (wr_en) begin
                wr_ptr    <= wr_ptr + LEN_ONE;
                frame_len <= frame_len + LEN_ONE;
            end
            if (valid_in && (error_in || no_space)) begin
                bad <= 1'b1;
            end
            if (valid_in && no_space) begin
                bad_ovf <= 1'b1;
            end
            // frame_end only occurs with valid_in low, so it never collides
            // with the write updates above.
            if (frame_end) begin
                frame_len <= '0;
                bad       <= 1'b0;
                bad_ovf   <= 1'b0;
                if (frame_drop) begin
                    wr_ptr <= commit_ptr;
                    if (drop_cnt != DROP_CNT_MAX) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end else begin
                    commit_ptr <= wr_ptr;
                end
            end
            if (lq_push) begin
                lq_mem[lq_wr_ptr[LEN_DEPTH-1:0]] <= frame_len;
                lq_wr_ptr <= lq_wr_ptr + LQ_PTR_W'(1);
            end
        end
    end

    // Read FSM: IDLE pops a length and issues the first word, READ issues one
    // word per cycle, GAP spaces frames so exactly IFG idle cycles separate
    // eof_out from the next sof_out.
    always_comb begin
        rd_state_d = rd_state;
        rem_d      = rem_q;
        gap_d      = gap_q;
        rd_en      = 1'b0;
        rd_sof     = 1'b0;
        rd_eof     = 1'b0;
        lq_pop     = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (!lq_empty) begin
                    lq_pop = 1'b1;
                    rd_en  = 1'b1;
                    rd_sof = 1'b1;
                    rem_d  = lq_head - LEN_ONE;
                    if (lq_head == LEN_ONE) begin
                        rd_eof     = 1'b1;
                        gap_d      = IFG_M1;
                        rd_state_d = RD_GAP;
                    end else begin
                        rd_state_d = RD_READ;
                    end
                end
            end
            RD_READ: begin
                rd_en = 1'b1;
                rem_d = rem_q - LEN_ONE;
                if (rem_q == LEN_ONE) begin
                    rd_eof     = 1'b1;
                    gap_d      = IFG_M1;
                    rd_state_d = RD_GAP;
                end
            end
            RD_GAP: begin
                if (gap_q == 4'd0) begin
                    rd_state_d = RD_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= RD_IDLE;
            rem_q     <= '0;
            gap_q     <= '0;
            rd_ptr    <= '0;
            lq_rd_ptr <= '0;
            rd_vld_q  <= 1'b0;
            rd_sof_q  <= 1'b0;
            rd_eof_q  <= 1'b0;
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            eof_out   <= 1'b0;
            data_out  <= '0;
        end else begin
            rd_state <= rd_state_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            if (rd_en) begin
                rd_ptr <= rd_ptr + LEN_ONE;
            end
            if (lq_pop) begin
                lq_rd_ptr <= lq_rd_ptr + LQ_PTR_W'(1);
            end
            // Stage 1 tracks the RAM read in flight, stage 2 is the output
            // register; data_out only loads with a valid word so it holds
            // otherwise.
            rd_vld_q  <= rd_en;
            rd_sof_q  <= rd_sof;
            rd_eof_q  <= rd_eof;
            valid_out <= rd_vld_q;
            sof_out   <= rd_vld_q && rd_sof_q;
            eof_out   <= rd_vld_q && rd_eof_q;
            if (rd_vld_q) begin
                data_out <= ram_rdata;
            end
        end
    end

    mac_vlg_frame_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (FIFO_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[FIFO_DEPTH-1:0]),
        .wdata (data_in),
        .re    (rd_en),
        .raddr (rd_ptr[FIFO_DEPTH-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mac_vlg_frame_fifo.sv
// Bench for mac_vlg_frame_fifo: two instances share the input stream, one with
// default sizing (256-word buffer) and one with a 16-word buffer so overflow
// cases are reachable. Expected words are queued as {sof, eof, data} when
// frames are issued; a negedge monitor pops and compares whatever each DUT
// presents.
module tb_mac_vlg_frame_fifo;

  localparam int IFG = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       error_in;

  logic [7:0]  data_out_a, data_out_b;
  logic        valid_out_a, valid_out_b;
  logic        sof_out_a, sof_out_b;
  logic        eof_out_a, eof_out_b;
  logic [15:0] drop_cnt_a, drop_cnt_b;
  logic        overflow_a, overflow_b;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];
  int neg_cnt = 0;
  int ovf_seen_a = 0;
  int ovf_seen_b = 0;
  bit in_frame_a = 1'b0;
  bit in_frame_b = 1'b0;
  bit gap_chk_en = 1'b0;
  bit have_prev_eof = 1'b0;
  int last_eof_neg = 0;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  mac_vlg_frame_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .LEN_DEPTH(3), .IFG(IFG)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .error_in(error_in),
    .data_out(data_out_a), .valid_out(valid_out_a), .sof_out(sof_out_a),
    .eof_out(eof_out_a), .drop_cnt(drop_cnt_a), .overflow(overflow_a)
  );

  mac_vlg_frame_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .LEN_DEPTH(3), .IFG(IFG)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .error_in(error_in),
    .data_out(data_out_b), .valid_out(valid_out_b), .sof_out(sof_out_b),
    .eof_out(eof_out_b), .drop_cnt(drop_cnt_b), .overflow(overflow_b)
  );

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    neg_cnt++;
    if (rst) begin
      in_frame_a = 1'b0;
      in_frame_b = 1'b0;
    end else begin
      if (overflow_a) ovf_seen_a++;
      if (overflow_b) ovf_seen_b++;
      if (in_frame_a) check_val("gapless_a", 32'(valid_out_a), 32'(1));
      if (in_frame_b) check_val("gapless_b", 32'(valid_out_b), 32'(1));
      if (valid_out_a) begin
        if (exp_q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_a: got %0h expected no output", {sof_out_a, eof_out_a, data_out_a});
        end else begin
          check_val("out_a", 32'({sof_out_a, eof_out_a, data_out_a}), 32'(exp_q_a.pop_front()));
        end
        if (sof_out_a && gap_chk_en && have_prev_eof)
          check_val("ifg_a", neg_cnt - last_eof_neg - 1, IFG);
        if (sof_out_a) in_frame_a = 1'b1;
        if (eof_out_a) begin
          in_frame_a = 1'b0;
          last_eof_neg = neg_cnt;
          have_prev_eof = 1'b1;
        end
      end
      if (valid_out_b) begin
        if (exp_q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_b: got %0h expected no output", {sof_out_b, eof_out_b, data_out_b});
        end else begin
          check_val("out_b", 32'({sof_out_b, eof_out_b, data_out_b}), 32'(exp_q_b.pop_front()));
        end
        if (sof_out_b) in_frame_b = 1'b1;
        if (eof_out_b) in_frame_b = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    error_in = 1'b0;
    data_in = 8'h00;
    exp_q_a.delete();
    exp_q_b.delete();
    ovf_seen_a = 0;
    ovf_seen_b = 0;
    have_prev_eof = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Leaves the bench at the negedge where valid_in was dropped, plus gap cycles.
  task automatic send_frame(input int len, input int start, input int err_idx, input int gap);
    for (int i = 0; i < len; i++) begin
      valid_in = 1'b1;
      data_in = 8'(start + i);
      error_in = (i == err_idx);
      @(negedge clk);
    end
    valid_in = 1'b0;
    error_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_exp(input bit to_a, input bit to_b, input int len, input int start);
    logic [9:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == 0), (i == len - 1), 8'(start + i)};
      if (to_a) exp_q_a.push_back(e);
      if (to_b) exp_q_b.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_%s: got %0d/%0d words outstanding expected 0",
               name, exp_q_a.size(), exp_q_b.size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic check_drops(input string name, input int da, input int db, input int oa, input int ob);
    check_val({name, "_drop_a"}, 32'(drop_cnt_a), da);
    check_val({name, "_drop_b"}, 32'(drop_cnt_b), db);
    check_val({name, "_ovf_a"}, ovf_seen_a, oa);
    check_val({name, "_ovf_b"}, ovf_seen_b, ob);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int d;
    rst = 1'b1;
    valid_in = 1'b0;
    error_in = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_valid_a", 32'(valid_out_a), 32'(0));
    check_val("rst_data_a", 32'(data_out_a), 32'(0));
    check_val("rst_sof_eof_a", 32'({sof_out_a, eof_out_a}), 32'(0));
    check_val("rst_drop_a", 32'(drop_cnt_a), 32'(0));
    check_val("rst_ovf_a", 32'(overflow_a), 32'(0));
    check_val("rst_valid_b", 32'(valid_out_b), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 64-word frame: A forwards it, B (16 words) overflows
    do_reset();
    push_exp(1'b1, 1'b0, 64, 0);
    send_frame(64, 0, -1, 0);
    n = 0;
    while (!valid_out_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("latency_a", n, 3);
    wait_drain("f64");
    check_drops("f64", 0, 1, 0, 1);

    // Errored 10-word frame then good 4-word frame
    do_reset();
    push_exp(1'b1, 1'b1, 4, 8'h40);
    send_frame(10, 8'h10, 5, 2);
    send_frame(4, 8'h40, -1, 2);
    wait_drain("err");
    check_drops("err", 1, 1, 0, 0);

    // 20-word frame (overflows B) then 16-word frame (exactly fills B)
    do_reset();
    push_exp(1'b1, 1'b0, 20, 8'h80);
    push_exp(1'b1, 1'b1, 16, 8'h20);
    send_frame(20, 8'h80, -1, 2);
    send_frame(16, 8'h20, -1, 2);
    wait_drain("ovf");
    check_drops("ovf", 0, 1, 0, 1);

    // Ten 1-word frames with 1-cycle gaps
    do_reset();
    gap_chk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_exp(1'b1, 1'b1, 1, 8'hA0 + i);
      send_frame(1, 8'hA0 + i, -1, 1);
    end
    wait_drain("single");
    gap_chk_en = 1'b0;
    check_drops("single", 0, 0, 0, 0);

    // Reset in the middle of a 32-word output frame
    do_reset();
    push_exp(1'b1, 1'b0, 32, 8'h60);
    send_frame(32, 8'h60, -1, 0);
    n = 0;
    while (exp_q_a.size() > 20 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_frame_valid_a", 32'(valid_out_a), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check_val("async_valid_a", 32'(valid_out_a), 32'(0));
    check_val("async_data_a", 32'(data_out_a), 32'(0));
    check_val("async_sof_eof_a", 32'({sof_out_a, eof_out_a}), 32'(0));
    check_val("async_drop_a", 32'(drop_cnt_a), 32'(0));
    check_val("async_drop_b", 32'(drop_cnt_b), 32'(0));
    exp_q_a.delete();
    exp_q_b.delete();
    ovf_seen_a = 0;
    ovf_seen_b = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(1'b1, 1'b1, 5, 8'h33);
    send_frame(5, 8'h33, -1, 2);
    wait_drain("post_rst");
    check_drops("post_rst", 0, 0, 0, 0);

    // 301-word stream of 7-word frames, wrapping both buffers
    do_reset();
    d = 0;
    for (int f = 0; f < 43; f++) begin
      push_exp(1'b1, 1'b1, 7, d);
      send_frame(7, d, -1, 2);
      d += 7;
    end
    wait_drain("stream");
    check_drops("stream", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
